// File: rtl/window_gen_3x3_pkg.sv
// Shared constants and the counter-width helper for the 3x3 window generator.
package window_gen_3x3_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 8;
  localparam int DEF_IMG_HEIGHT = 8;

  // A counter for n positions needs at least one bit, even for degenerate n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, 3x3 window out; slave is the generator side.
interface window_gen_3x3_if;
  import window_gen_3x3_pkg::*;

  logic             iDataValid;
  logic [PIX_W-1:0] iv8Pixel;
  logic [PIX_W-1:0] ov8Pixel_a;
  logic [PIX_W-1:0] ov8Pixel_b;
  logic [PIX_W-1:0] ov8Pixel_c;
  logic [PIX_W-1:0] ov8Pixel_d;
  logic [PIX_W-1:0] ov8Pixel_fij;
  logic [PIX_W-1:0] ov8Pixel_e;
  logic [PIX_W-1:0] ov8Pixel_f;
  logic [PIX_W-1:0] ov8Pixel_g;
  logic [PIX_W-1:0] ov8Pixel_h;
  logic             oDataValid;
  logic             oFrameDone;

  modport slave (
    input  iDataValid, iv8Pixel,
    output ov8Pixel_a, ov8Pixel_b, ov8Pixel_c,
           ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e,
           ov8Pixel_f, ov8Pixel_g, ov8Pixel_h,
           oDataValid, oFrameDone
  );

  modport master (
    output iDataValid, iv8Pixel,
    input  ov8Pixel_a, ov8Pixel_b, ov8Pixel_c,
           ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e,
           ov8Pixel_f, ov8Pixel_g, ov8Pixel_h,
           oDataValid, oFrameDone
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// Circular line delay: each enabled cycle returns the pixel written DEPTH enables ago.
module line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int PW = cnt_width(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;

  // Read-before-write on the same slot gives exactly DEPTH cycles of delay.
  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == PW'(DEPTH - 1)) ptr_d = '0;
      else                         ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Contents are fully rewritten by the first two lines after reset.
  always_ff @(posedge iClk) begin
    if (en) mem_q[ptr_q] <= din;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream 3x3 window generator: two line delays feed a 3-column shift window.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             iClk,
  input  logic             iRst,
  window_gen_3x3_if.slave  bus
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Indexed [window row][window col]; row 0 is the oldest line, col 0 the leftmost.
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [2:0][2:0][PIX_W-1:0] out_q, out_d;
  logic                       dv_q, dv_d;
  logic                       fd_q, fd_d;

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic [PIX_W-1:0] line1_dly;
  logic [PIX_W-1:0] line2_dly;

  assign accept   = bus.iDataValid;
  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
    .iClk (iClk),
    .iRst (iRst),
    .en   (accept),
    .din  (bus.iv8Pixel),
    .dout (line1_dly)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line2 (
    .iClk (iClk),
    .iRst (iRst),
    .en   (accept),
    .din  (line1_dly),
    .dout (line2_dly)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    out_d = out_q;
    dv_d  = 1'b0;
    fd_d  = 1'b0;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][2] = line2_dly;
      win_d[1][2] = line1_dly;
      win_d[2][2] = bus.iv8Pixel;

      // Only windows whose centre is off the border are emitted.
      if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
        out_d = win_d;
        dv_d  = 1'b1;
        fd_d  = row_last && col_last;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      out_q <= '0;
      dv_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      out_q <= out_d;
      dv_q  <= dv_d;
      fd_q  <= fd_d;
    end
  end

  assign bus.ov8Pixel_a   = out_q[0][0];
  assign bus.ov8Pixel_b   = out_q[0][1];
  assign bus.ov8Pixel_c   = out_q[0][2];
  assign bus.ov8Pixel_d   = out_q[1][0];
  assign bus.ov8Pixel_fij = out_q[1][1];
  assign bus.ov8Pixel_e   = out_q[1][2];
  assign bus.ov8Pixel_f   = out_q[2][0];
  assign bus.ov8Pixel_g   = out_q[2][1];
  assign bus.ov8Pixel_h   = out_q[2][2];
  assign bus.oDataValid   = dv_q;
  assign bus.oFrameDone   = fd_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed and random pixel streams checked against an image-array window model.
module tb_window_gen_3x3;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n;

  window_gen_3x3_if bus ();
  window_gen_3x3_if bus3 ();

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .iClk (clk),
    .iRst (rst_n),
    .bus  (bus)
  );

  window_gen_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
    .iClk (clk),
    .iRst (rst_n),
    .bus  (bus3)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: raster position plus the pixels of the current frame.
  int          mr, mc;
  logic [7:0]  img [H][W];
  logic [71:0] exp_win;
  int          win_cnt, fd_cnt;

  function automatic logic [71:0] dut_win();
    return {bus.ov8Pixel_a, bus.ov8Pixel_b, bus.ov8Pixel_c,
            bus.ov8Pixel_d, bus.ov8Pixel_fij, bus.ov8Pixel_e,
            bus.ov8Pixel_f, bus.ov8Pixel_g, bus.ov8Pixel_h};
  endfunction

  function automatic logic [71:0] dut3_win();
    return {bus3.ov8Pixel_a, bus3.ov8Pixel_b, bus3.ov8Pixel_c,
            bus3.ov8Pixel_d, bus3.ov8Pixel_fij, bus3.ov8Pixel_e,
            bus3.ov8Pixel_f, bus3.ov8Pixel_g, bus3.ov8Pixel_h};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0;
    mc = 0;
    exp_win = '0;
  endtask

  // One cycle: drive, let the edge happen, check everything one step later.
  task automatic send(input bit v, input logic [7:0] p);
    bit exp_dv, exp_fd;
    exp_dv = 1'b0;
    exp_fd = 1'b0;
    bus.iDataValid = v;
    bus.iv8Pixel   = p;
    if (v) begin
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        exp_dv  = 1'b1;
        exp_fd  = (mr == H-1) && (mc == W-1);
        exp_win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                   img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                   img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
    @(posedge clk);
    #1;
    check("dv", 72'(bus.oDataValid), 72'(exp_dv));
    check("fd", 72'(bus.oFrameDone), 72'(exp_fd));
    check("win", dut_win(), exp_win);
    if (bus.oDataValid) win_cnt++;
    if (bus.oFrameDone) fd_cnt++;
  endtask

  task automatic send_ramp(input int offset, input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1'b1, 8'(r*W + c + offset));
        if (gaps) send(1'b0, 8'($urandom));
      end
    end
  endtask

  logic [71:0] last_ramp_win;
  logic [71:0] first_win;
  logic [71:0] mini_win;

  initial begin
    last_ramp_win = {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63};
    first_win     = {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
    mini_win      = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};

    bus.iDataValid  = 1'b0;
    bus.iv8Pixel    = '0;
    bus3.iDataValid = 1'b0;
    bus3.iv8Pixel   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dv", 72'(bus.oDataValid), 72'(0));
    check("rst_fd", 72'(bus.oFrameDone), 72'(0));
    check("rst_win", dut_win(), 72'(0));
    rst_n = 1'b1;
    send(1'b0, 8'hAA);

    // Continuous ramp; the first window appears right after pixel 18.
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 19; i++) send(1'b1, 8'(i));
    check("ramp_first_win", dut_win(), first_win);
    for (int i = 19; i < W*H; i++) send(1'b1, 8'(i));
    check("ramp_wins", 72'(win_cnt), 72'(36));
    check("ramp_fd", 72'(fd_cnt), 72'(1));
    check("ramp_last_win", dut_win(), last_ramp_win);

    // Same ramp with valid low every other cycle.
    win_cnt = 0; fd_cnt = 0;
    send_ramp(0, 1'b1);
    check("gap_wins", 72'(win_cnt), 72'(36));
    check("gap_last_win", dut_win(), last_ramp_win);

    // Back-to-back frames, second offset by 64.
    win_cnt = 0; fd_cnt = 0;
    send_ramp(0, 1'b0);
    send_ramp(64, 1'b0);
    check("b2b_wins", 72'(win_cnt), 72'(72));
    check("b2b_fd", 72'(fd_cnt), 72'(2));

    // Random pixels with random valid gaps across three frames.
    win_cnt = 0; fd_cnt = 0;
    for (int n = 0; n < 3*W*H; ) begin
      if ($urandom_range(0, 3) != 0) begin
        send(1'b1, 8'($urandom));
        n++;
      end else begin
        send(1'b0, 8'($urandom));
      end
    end
    check("rand_wins", 72'(win_cnt), 72'(108));
    check("rand_fd", 72'(fd_cnt), 72'(3));

    // Reset after 30 pixels discards the partial frame.
    for (int i = 0; i < 30; i++) send(1'b1, 8'($urandom));
    bus.iDataValid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_win", dut_win(), 72'(0));
    check("midrst_dv", 72'(bus.oDataValid), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_win", dut_win(), 72'(0));
    check("midrst_fd", 72'(bus.oFrameDone), 72'(0));
    rst_n = 1'b1;
    model_reset();
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 19; i++) send(1'b1, 8'(i));
    check("post_rst_first", dut_win(), first_win);
    for (int i = 19; i < W*H; i++) send(1'b1, 8'(i));
    check("post_rst_wins", 72'(win_cnt), 72'(36));

    // Minimum 3x3 image: one window on the final pixel.
    for (int i = 1; i <= 9; i++) begin
      bus3.iDataValid = 1'b1;
      bus3.iv8Pixel   = 8'(i);
      @(posedge clk);
      #1;
      check("mini_dv", 72'(bus3.oDataValid), 72'(i == 9));
      check("mini_fd", 72'(bus3.oFrameDone), 72'(i == 9));
    end
    check("mini_win", dut3_win(), mini_win);
    bus3.iDataValid = 1'b0;
    @(posedge clk);
    #1;
    check("mini_dv_drop", 72'(bus3.oDataValid), 72'(0));
    check("mini_hold", dut3_win(), mini_win);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 8, pixels per line, legal range 3..1024.
REQ-002 SHALL have parameter IMG_HEIGHT, default 8, lines per frame, legal range 3..1024.
REQ-003 iClk  input  1  single clock; all state updates on its rising edge.
REQ-004 iRst  input  1  asynchronous, active-low reset.
REQ-005 iDataValid  input  1  qualifies iv8Pixel; one raster-order pixel accepted per cycle it is high.
REQ-006 iv8Pixel  input  8  incoming pixel, left-to-right, top-to-bottom.
REQ-007 ov8Pixel_a / _b / _c  output  8 each  window top row, left to right.
REQ-008 ov8Pixel_d / _fij / _e  output  8 each  window middle row; _fij is the centre pixel.
REQ-009 ov8Pixel_f / _g / _h  output  8 each  window bottom row, left to right.
REQ-010 oDataValid  output  1  one-cycle strobe per complete 3x3 window; feeds the denoising top's iDataValid.
REQ-011 oFrameDone  output  1  one-cycle strobe coincident with the last window of a frame.

Function
REQ-012 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advanced only on accepted pixels.
REQ-013 col SHALL wrap to 0 after IMG_WIDTH-1 and increment row; row SHALL wrap to 0 after IMG_HEIGHT-1, so back-to-back frames need no idle cycles.
REQ-014 SHALL hold two line buffers of IMG_WIDTH x 8 bits, delaying the stream by exactly one and two lines.
REQ-015 On each accepted pixel, SHALL shift a 3-column register window left and load the right column from {2-line delayed, 1-line delayed, current pixel}.
REQ-016 Window mapping: a,b,c = line row-2, cols col-2..col; d,fij,e = line row-1; f,g,h = line row.
REQ-017 oDataValid SHALL assert exactly one cycle after an accepted pixel with row>=2 and col>=2, and is low otherwise.
REQ-018 Windows whose centre lies on the image border SHALL NOT be emitted; exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-019 Window outputs SHALL be registered and SHALL hold their last value while oDataValid is low.
REQ-020 When iDataValid is low, counters, line buffers, window and outputs SHALL hold; oDataValid and oFrameDone go low.
REQ-021 oFrameDone SHALL assert in the same cycle as oDataValid for the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-022 Latency SHALL be 1 cycle from accepting the completing pixel to oDataValid; throughput SHALL be one window per cycle.
REQ-023 Counter widths SHALL be $clog2 of the parameter; no overflow occurs at the maximum parameter values.

Reset
REQ-024 While iRst is low: col, row, window registers and all outputs SHALL be 0, oDataValid=0, oFrameDone=0.
REQ-025 Line-buffer contents need no reset; the first two lines after reset fully overwrite them before any window is emitted.
REQ-026 A reset mid-frame SHALL discard the partial frame; the next accepted pixel is treated as (0,0).

Structure
REQ-027 Shared package SHALL hold the pixel width constant (8), the default IMG_WIDTH/IMG_HEIGHT, and the counter-width function.
REQ-028 One sub-module, line_buffer (parameterised depth, 8-bit, enable-gated circular RAM with a single read/write pointer), SHALL be instantiated twice.

Verification
REQ-029 8x8 ramp (pixel=row*8+col), continuous valid -> first oDataValid one cycle after pixel 18, with a=0 b=1 c=2 d=8 fij=9 e=10 f=16 g=17 h=18; 36 windows total; oFrameDone with the window a=45..h=63.
REQ-030 Same ramp with iDataValid low on every other cycle -> identical window sequence and values; oDataValid never high on two consecutive cycles.
REQ-031 Left-edge check: pixels (3,0) and (3,1) -> no oDataValid; pixel (3,2) -> window fij=17.
REQ-032 Two back-to-back 8x8 frames, second frame = ramp+64 -> 72 windows, oFrameDone twice, second frame's first window fij=73, with no contamination from frame 1.
REQ-033 iRst low after 30 pixels, then release and send a full ramp -> all outputs 0 during reset; afterwards exactly 36 windows, first fij=9.
REQ-034 Minimum size IMG_WIDTH=3, IMG_HEIGHT=3, pixels 1..9 -> a single window, a=1..h=9, with oDataValid and oFrameDone both high.
